// File: rtl/bldc_pwm_commutator_pkg.sv
// bldc_pkg: hall codes, phase indices and the commutation table lookup (code,dir -> valid/sector/hi/lo) shared by the BLDC stage
package bldc_pkg;
  localparam logic [2:0] HALL_S0 = 3'd5, HALL_S1 = 3'd4, HALL_S2 = 3'd6;
  localparam logic [2:0] HALL_S3 = 3'd2, HALL_S4 = 3'd3, HALL_S5 = 3'd1;
  localparam int PH_A = 0, PH_B = 1, PH_C = 2;
  localparam logic [2:0] M_A = 3'b1 << PH_A, M_B = 3'b1 << PH_B, M_C = 3'b1 << PH_C;
  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
    logic [2:0] hi;
    logic [2:0] lo;
  } comm_t;
  function automatic comm_t comm_lookup(input logic [2:0] code, input logic dir);
    logic       v;
    logic [2:0] s, hi, lo;
    v  = 1'b1;
    s  = 3'd0;
    hi = 3'b000;
    lo = 3'b000;
    case (code)
      HALL_S0: begin s = 3'd0; hi = M_A; lo = M_B; end
      HALL_S1: begin s = 3'd1; hi = M_A; lo = M_C; end
      HALL_S2: begin s = 3'd2; hi = M_B; lo = M_C; end
      HALL_S3: begin s = 3'd3; hi = M_B; lo = M_A; end
      HALL_S4: begin s = 3'd4; hi = M_C; lo = M_A; end
      HALL_S5: begin s = 3'd5; hi = M_C; lo = M_B; end
      default: v = 1'b0;
    endcase
    return dir ? comm_t'{v, s, lo, hi} : comm_t'{v, s, hi, lo};
  endfunction
endpackage

// File: rtl/bldc_pwm_commutator_if.sv
// bldc_pwm_commutator_if: control/hall inputs (enable,dir,duty,hall,fault_clr) and gate/status outputs (gate_hi,gate_lo,sector,period_start,fault)
interface bldc_pwm_commutator_if #(parameter int PWM_WIDTH = 9);
  logic                 enable, dir, fault_clr, period_start, fault;
  logic [PWM_WIDTH-1:0] duty;
  logic [2:0]           hall, gate_hi, gate_lo, sector;
  modport master (output enable, dir, duty, hall, fault_clr, input gate_hi, gate_lo, sector, period_start, fault);
  modport slave  (input enable, dir, duty, hall, fault_clr, output gate_hi, gate_lo, sector, period_start, fault);
endinterface

// File: rtl/bldc_pwm_commutator_deadtime_gate.sv
// deadtime_gate: one phase; hi_req/lo_req in, registered gate_hi/gate_lo out, complement held off DEADTIME cycles after a gate falls
module deadtime_gate #(
  parameter int DEADTIME = 8,
  parameter int DT_WIDTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic hi_req,
  input  logic lo_req,
  output logic gate_hi,
  output logic gate_lo
);
  logic [DT_WIDTH-1:0] dt_cnt;
  logic fell_hi, fell_lo, clash, dt_idle, hi_n, lo_n, fall;
  always_comb begin
    clash   = hi_req & lo_req;
    dt_idle = dt_cnt == '0;
    hi_n    = hi_req & !clash & (gate_hi | (!gate_lo & (dt_idle | !fell_lo)));
    lo_n    = lo_req & !clash & (gate_lo | (!gate_hi & (dt_idle | !fell_hi)));
    fall    = (gate_hi & !hi_n) | (gate_lo & !lo_n);
  end
  always_ff @(posedge CLK)
    if (RST) begin
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      fell_hi <= 1'b1;
      fell_lo <= 1'b1;
      dt_cnt  <= DT_WIDTH'(DEADTIME);
    end else begin
      gate_hi <= hi_n;
      gate_lo <= lo_n;
      fell_hi <= (gate_hi & !hi_n) ? 1'b1 : (gate_lo & !lo_n) ? 1'b0 : fell_hi;
      fell_lo <= (gate_lo & !lo_n) ? 1'b1 : (gate_hi & !hi_n) ? 1'b0 : fell_lo;
      dt_cnt  <= fall ? DT_WIDTH'(DEADTIME) : dt_idle ? dt_cnt : dt_cnt - DT_WIDTH'(1);
    end
endmodule

// File: rtl/bldc_pwm_commutator.sv
// bldc_pwm_commutator: PWM counter/duty shadow, hall sync+decode, sticky fault, 3x deadtime_gate; ports CLK, RST, bus (slave)
module bldc_pwm_commutator
  import bldc_pkg::*;
#(
  parameter int PWM_WIDTH = 9,
  parameter int DEADTIME  = 8,
  parameter int DT_WIDTH  = 4
) (
  input logic CLK,
  input logic RST,
  bldc_pwm_commutator_if.slave bus
);
  logic [PWM_WIDTH-1:0] cnt, duty_q;
  logic [2:0] hall_s1, hall_s2, tbl_hi, tbl_lo, hi_req, lo_req, gate_hi, gate_lo;
  logic [1:0] sync_vld;
  logic pwm_on, run;
  comm_t dec;
  always_comb begin
    dec    = comm_lookup(hall_s2, bus.dir);
    pwm_on = cnt < duty_q;
    run    = bus.enable & !bus.fault;
    hi_req = {3{run & pwm_on}} & tbl_hi;
    lo_req = {3{run}} & tbl_lo;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      cnt              <= '0;
      duty_q           <= '0;
      bus.period_start <= 1'b0;
      hall_s1          <= 3'b000;
      hall_s2          <= 3'b000;
      sync_vld         <= 2'b00;
      bus.fault        <= 1'b0;
      bus.sector       <= 3'd0;
      tbl_hi           <= 3'b000;
      tbl_lo           <= 3'b000;
    end else begin
      cnt              <= cnt + PWM_WIDTH'(1);
      duty_q           <= &cnt ? bus.duty : duty_q;
      bus.period_start <= &cnt;
      hall_s1          <= bus.hall;
      hall_s2          <= hall_s1;
      sync_vld         <= {sync_vld[0], 1'b1};
      // the zeroed synchroniser is not a real hall sample, so decode waits until it has been refilled
      if (sync_vld[1]) begin
        bus.fault <= !dec.valid | (bus.fault & !bus.fault_clr);
        if (dec.valid) begin
          bus.sector <= dec.sector;
          tbl_hi     <= dec.hi;
          tbl_lo     <= dec.lo;
        end
      end
    end
  for (genvar p = 0; p < 3; p++) begin : g_dt
    deadtime_gate #(.DEADTIME(DEADTIME), .DT_WIDTH(DT_WIDTH)) u_dt (
      .CLK(CLK), .RST(RST), .hi_req(hi_req[p]), .lo_req(lo_req[p]),
      .gate_hi(gate_hi[p]), .gate_lo(gate_lo[p])
    );
  end
  assign bus.gate_hi = gate_hi;
  assign bus.gate_lo = gate_lo;
endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// tb_bldc_pwm_commutator: directed steps with a per-period PWM scoreboard and immediate-assertion checks
module tb_bldc_pwm_commutator;
  localparam int W = 9, DT = 8, P = 512;
  logic CLK = 1'b0, RST = 1'b1;
  always #5 CLK = ~CLK;
  bldc_pwm_commutator_if #(.PWM_WIDTH(W)) bus ();
  bldc_pwm_commutator #(.PWM_WIDTH(W), .DEADTIME(DT), .DT_WIDTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {int hp; int hn; int lp; int ln;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0, plen = 0;
  int acc_hi[3] = '{0, 0, 0}, acc_lo[3] = '{0, 0, 0};
  int codes[6] = '{5, 4, 6, 2, 3, 1};
  int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
  int lo_ph[6] = '{1, 2, 2, 0, 0, 1};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge CLK) begin
    chk("no_overlap", {29'd0, bus.gate_hi & bus.gate_lo}, 0);
    for (int p = 0; p < 3; p++) begin
      acc_hi[p] += int'(bus.gate_hi[p]);
      acc_lo[p] += int'(bus.gate_lo[p]);
    end
    plen++;
    if (bus.period_start) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("pwm_hi[%0d]", e.hp), acc_hi[e.hp], e.hn);
        chk($sformatf("pwm_lo[%0d]", e.lp), acc_lo[e.lp], e.ln);
        chk("period_len", plen, P);
      end
      acc_hi = '{0, 0, 0};
      acc_lo = '{0, 0, 0};
      plen = 0;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic wait_ps();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!bus.period_start && k < 600);
    chk("period_start_seen", bus.period_start, 1);
    #1;
  endtask
  task automatic period(input int exp_d, input int hp, input int lp, input int nd, input int at);
    wait_ps();
    sb.push_back('{hp, exp_d, lp, P});
    cyc(at);
    bus.duty = W'(nd);
  endtask
  initial begin
    int k, fb, rc, kp;
    bus.enable = 0; bus.dir = 0; bus.duty = '0; bus.hall = 3'd5; bus.fault_clr = 0;
    cyc(3);
    chk("rst_gate_hi", bus.gate_hi, 0);
    chk("rst_gate_lo", bus.gate_lo, 0);
    chk("rst_sector", bus.sector, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_period_start", bus.period_start, 0);
    RST = 0; bus.enable = 1; bus.duty = W'(100);
    k = 0;
    while (bus.gate_hi == 0 && bus.gate_lo == 0 && k < 40) begin cyc(1); k++; end
    chk("first_rise_after_dt", k >= DT && k < 40, 1);
    chk("first_rise_lo_b", bus.gate_lo, 3'b010);
    period(100, 0, 1, 100, 0);
    period(100, 0, 1, 300, 200);
    period(300, 0, 1, 0, 50);
    period(0, 0, 1, 511, 50);
    period(511, 0, 1, 100, 50);
    wait_ps();
    bus.hall = 3'd4; fb = 0; rc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (fb == 0 && !bus.gate_lo[1]) fb = i;
      if (rc == 0 && bus.gate_lo[2]) rc = i;
    end
    chk("lo_b_fall_latency", fb, 4);
    chk("lo_c_rise_window", rc >= 4 && rc <= 4 + DT + 1, 1);
    chk("sector_s1", bus.sector, 1);
    wait_ps();
    cyc(10);
    bus.hall = 3'd6;
    cyc(3);
    chk("hi_a_before_off", bus.gate_hi[0], 1);
    cyc(1);
    chk("hi_a_off_latency", bus.gate_hi[0], 0);
    chk("sector_s2", bus.sector, 2);
    period(100, 1, 2, 100, 0);
    wait_ps();
    bus.dir = 1; bus.hall = 3'd5;
    cyc(20);
    period(100, 1, 0, 100, 0);
    wait_ps();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 6; s++) begin
        bus.dir = d[0]; bus.hall = codes[s][2:0];
        cyc(16);
        chk($sformatf("sweep_sector_d%0d_s%0d", d, s), bus.sector, s);
        chk($sformatf("sweep_lo_d%0d_s%0d", d, s), bus.gate_lo, 1 << (d ? hi_ph[s] : lo_ph[s]));
        chk($sformatf("sweep_hi_d%0d_s%0d", d, s), bus.gate_hi & ~(3'b1 << (d ? lo_ph[s] : hi_ph[s])), 0);
      end
    bus.dir = 0; bus.hall = 3'd5;
    cyc(16);
    bus.hall = 3'd7;
    cyc(3);
    chk("fault_set", bus.fault, 1);
    chk("fault_lo_still_on", bus.gate_lo, 3'b010);
    cyc(1);
    chk("fault_gate_hi", bus.gate_hi, 0);
    chk("fault_gate_lo", bus.gate_lo, 0);
    chk("fault_sector_held", bus.sector, 0);
    cyc(20);
    bus.fault_clr = 1; cyc(1); bus.fault_clr = 0;
    chk("fault_clr_invalid", bus.fault, 1);
    bus.hall = 3'd5;
    cyc(4);
    chk("fault_sticky", bus.fault, 1);
    bus.fault_clr = 1; cyc(1); bus.fault_clr = 0;
    chk("fault_cleared", bus.fault, 0);
    k = 0;
    while (bus.gate_lo != 3'b010 && k < 20) begin cyc(1); k++; end
    chk("resume_lo_b", bus.gate_lo, 3'b010);
    chk("resume_bound", k <= DT + 2, 1);
    k = 0;
    while (!bus.gate_hi[0] && k < 600) begin cyc(1); k++; end
    chk("hi_a_active", bus.gate_hi[0], 1);
    bus.enable = 0; cyc(1);
    chk("enable_off_hi", bus.gate_hi, 0);
    chk("enable_off_lo", bus.gate_lo, 0);
    bus.enable = 1;
    k = 0;
    while (!bus.gate_hi[0] && k < 600) begin cyc(1); k++; end
    chk("hi_a_active_again", bus.gate_hi[0], 1);
    RST = 1; cyc(1);
    chk("midrst_gate_hi", bus.gate_hi, 0);
    chk("midrst_gate_lo", bus.gate_lo, 0);
    chk("midrst_fault", bus.fault, 0);
    chk("midrst_sector", bus.sector, 0);
    chk("midrst_period_start", bus.period_start, 0);
    RST = 0;
    k = 0; kp = 0;
    for (int i = 1; i <= 600 && kp == 0; i++) begin
      @(negedge CLK);
      if (k == 0 && (bus.gate_hi != 0 || bus.gate_lo != 0)) k = i;
      if (bus.period_start) kp = i;
    end
    chk("midrst_first_rise", k >= DT, 1);
    chk("midrst_cnt_restart", kp, P);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
